cv_pe_arbiter: RTL
==================

# cv_pe_arbiter

Shares the single external memory port (read and write channels) among `NPE` convolution PE data loaders so several conv cores can run in one layer. Sits between the per-PE loader memory bundles and the top-level layer mux, in the slot the conv path currently drives directly. Arbitration is round-robin with optional burst locking. One PE owns the whole port at a time, and read data is returned only to the owner.

## Interface
- `NPE`, default 4: number of requesting PEs (2..8).
- `MAX_BURST`, default 64: maximum beats per grant when burst lock is compiled in (1..255).
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `pe_rvalid`  in  NPE  per-PE read request.
- `pe_raddr`  in  NPE*26  per-PE read address; PE i occupies bits [26i+25:26i].
- `pe_rready`  out  NPE  read beat returned to the owner.
- `pe_rdata`  out  NPE*32  per-PE read data; zero for non-owners.
- `pe_wvalid`  in  NPE  per-PE write request.
- `pe_waddr`  in  NPE*26  per-PE write address.
- `pe_wdata`  in  NPE*32  per-PE write data.
- `pe_wready`  out  NPE  write beat accepted for the owner.
- `rvalid`  out  1  read request to memory.
- `raddr`  out  26  read address to memory.
- `rready`  in  1  memory read data valid.
- `rdata`  in  32  memory read data.
- `wvalid`  out  1  write request to memory.
- `waddr`  out  26  write address to memory.
- `wdata`  out  32  write data to memory.
- `wready`  in  1  memory write accepted.
- `grant`  out  NPE  one-hot owner; all zero when idle.
- `busy`  out  1  high in BUSY state.

## Operation
- PE i requests the port when `req[i] = pe_rvalid[i] | pe_wvalid[i]`.
- States:
  - IDLE: outputs are all gated off. If any `req` is high, the arbiter picks the first requester at or after `ptr` (cyclic search), registers it into `grant`, clears `beats`, and moves to BUSY. With no requests it stays in IDLE.
  - BUSY: the owner g is forwarded through combinational muxes:
    - `rvalid = pe_rvalid[g]`, `raddr = pe_raddr[g]`.
    - `wvalid = pe_wvalid[g]`, `waddr = pe_waddr[g]`, `wdata = pe_wdata[g]`.
    - `pe_rready[g] = rready`, `pe_wready[g] = wready`.
    - `pe_rdata` slice g equals `rdata`; all other slices are 0. All other `pe_rready` and `pe_wready` bits are 0.
- Beat counting: a beat is any cycle in BUSY with `rready | wready`. A cycle with both asserted counts as one beat. `beats` is 8-bit and saturates at 255.
- Release: the arbiter goes to IDLE on the next edge, clears `grant`, and sets `ptr = (g+1) mod NPE` when either of these holds:
  - `req[g]` is low, or
  - the release condition in Configuration is met.
- `rready` or `wready` arriving while in IDLE is ignored and is not forwarded.
- If a non-owner drops its request before being granted, nothing is recorded for it.

## Timing
- Reset values, with `rst_n` low at an edge: state IDLE, `grant` 0, `ptr` 0, `beats` 0, `busy` 0. All downstream and per-PE outputs are 0 from the next cycle.
- Reset mid-transaction aborts the grant immediately. An in-flight memory beat is dropped.
- Grant latency: a request sampled in IDLE at edge t produces `grant` and forwarded `rvalid`/`wvalid` valid after edge t. Best case, a new grant is visible one cycle after the request.
- Handover costs exactly one IDLE bubble cycle between owners.
- Forwarding in BUSY is purely combinational and adds no cycles to memory handshakes.
- Fairness: a continuously requesting PE waits at most `NPE-1` grants.

## Configuration
- `CV_ARB_BURST_LOCK_EN` defined: the grant is held while the owner requests, up to `MAX_BURST` beats. It is released on the edge where a beat completes with `beats == MAX_BURST-1`.
- `CV_ARB_BURST_LOCK_EN` undefined: the grant is released after every completed beat (per-beat round-robin). `MAX_BURST` is ignored.

## Test plan
- Single requester: PE2 asserts `pe_rvalid` with addr 0x100 in IDLE. Expect `grant`=0100 and `raddr`=0x100 one cycle later. Memory `rready` with `rdata`=0xDEADBEEF gives `pe_rdata` slice 2 = 0xDEADBEEF, other slices 0, and `pe_rready`=0100.
- Round-robin: all four PEs request continuously, with memory answering each beat, and burst lock off. Expect grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Burst lock on, `MAX_BURST`=4: PE0 and PE1 request 10 beats each. Expect PE0 to get 4 beats, then PE1 4, then PE0 4, and so on. `busy` drops for one cycle at each handover.
- Owner drops its request early: PE1 deasserts after 2 beats with PE3 waiting. Expect IDLE on the next edge, then `grant`=1000, with `ptr` advanced past PE1.
- Combined read and write: owner PE0 asserts `pe_wvalid` with addr 0x20 and data 0x5A5A, and `pe_rvalid` with addr 0x40. Both are forwarded. `wready` and `rready` in the same cycle count as one beat.
- Reset mid-burst: `rst_n` low during a PE3 burst. Expect `grant`=0, `rvalid`=`wvalid`=0, and `ptr`=0 after the edge. After release, PE0 wins a simultaneous request from PE0 and PE3.

Source files
------------

// File: rtl/cv_pe_arbiter.sv
// -----------------------------------------------------------------------------
// cv_pe_arbiter
//   Shares the single external memory port (read + write channels) among NPE
//   convolution PE data loaders. One PE owns the whole port at a time; the
//   owner is chosen round-robin and read data is returned only to the owner.
//
//   Optional feature macro: CV_ARB_BURST_LOCK_EN
//     defined   : the owner keeps the port while it requests, for up to
//                 MAX_BURST beats.
//     undefined : the grant is released after every completed beat
//                 (per-beat round-robin); MAX_BURST has no effect.
//
// Parameters
//   NPE        number of requesting PEs (2..8)
//   MAX_BURST  beats per grant with burst lock compiled in (1..255)
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   pe_rvalid/pe_raddr         per-PE read request and address (26b per PE)
//   pe_rready/pe_rdata         per-PE read beat strobe and data (owner only)
//   pe_wvalid/pe_waddr/pe_wdata per-PE write request, address, data
//   pe_wready                  per-PE write accept (owner only)
//   rvalid/raddr/rready/rdata  memory read channel
//   wvalid/waddr/wdata/wready  memory write channel
//   grant                      one-hot owner, zero when idle
//   busy                       high while a PE owns the port
// -----------------------------------------------------------------------------
module cv_pe_arbiter #(
  parameter int NPE       = 4,
  parameter int MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPE-1:0]    pe_rvalid,
  input  logic [NPE*26-1:0] pe_raddr,
  output logic [NPE-1:0]    pe_rready,
  output logic [NPE*32-1:0] pe_rdata,
  input  logic [NPE-1:0]    pe_wvalid,
  input  logic [NPE*26-1:0] pe_waddr,
  input  logic [NPE*32-1:0] pe_wdata,
  output logic [NPE-1:0]    pe_wready,
  output logic              rvalid,
  output logic [25:0]       raddr,
  input  logic              rready,
  input  logic [31:0]       rdata,
  output logic              wvalid,
  output logic [25:0]       waddr,
  output logic [31:0]       wdata,
  input  logic              wready,
  output logic [NPE-1:0]    grant,
  output logic              busy
);

  localparam int PW = (NPE > 1) ? $clog2(NPE) : 1;

`ifdef CV_ARB_BURST_LOCK_EN
  localparam logic [7:0] LP_LAST_BEAT = 8'(MAX_BURST - 1);
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  logic [NPE-1:0]  r_grant;
  logic [PW-1:0]   r_gidx;
  logic [PW-1:0]   r_ptr;
  logic [7:0]      r_beats;

  state_t          w_state_nxt;
  logic [NPE-1:0]  w_grant_nxt;
  logic [PW-1:0]   w_gidx_nxt;
  logic [PW-1:0]   w_ptr_nxt;
  logic [7:0]      w_beats_nxt;

  logic [NPE-1:0]  w_req;
  logic            w_beat;
  logic            w_found;
  logic [PW-1:0]   w_pick;
  logic [3:0]      w_cand;
  logic            w_owner_req;
  logic            w_limit;
  logic            w_release;

  assign grant = r_grant;
  assign busy  = (r_state == ST_BUSY);

  // Next-state logic, round-robin pick and owner forwarding muxes.
  always_comb begin
    w_req       = pe_rvalid | pe_wvalid;
    w_beat      = rready | wready;

    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    w_beats_nxt = r_beats;

    rvalid      = 1'b0;
    raddr       = 26'd0;
    wvalid      = 1'b0;
    waddr       = 26'd0;
    wdata       = 32'd0;
    pe_rready   = '0;
    pe_wready   = '0;
    pe_rdata    = '0;

    // Cyclic search: first requester at or after r_ptr.
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = 4'd0;
    for (int k = 0; k < NPE; k++) begin
      w_cand = 4'(r_ptr) + 4'(k);
      if (w_cand >= 4'(NPE)) begin
        w_cand = w_cand - 4'(NPE);
      end else begin
        w_cand = w_cand;
      end
      if (!w_found && w_req[w_cand[PW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[PW-1:0];
      end else begin
        w_found = w_found;
      end
    end

    w_owner_req = |(w_req & r_grant);

`ifdef CV_ARB_BURST_LOCK_EN
    // Hold the port until the MAX_BURST-th beat completes.
    w_limit = w_beat && (r_beats == LP_LAST_BEAT);
`else
    // Per-beat round-robin: every completed beat hands the port on.
    w_limit = w_beat;
`endif

    w_release = !w_owner_req || w_limit;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = {{(NPE-1){1'b0}}, 1'b1} << w_pick;
          w_gidx_nxt  = w_pick;
          w_beats_nxt = 8'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // r_grant is one-hot, so at most one slice is selected.
        for (int i = 0; i < NPE; i++) begin
          if (r_grant[i]) begin
            rvalid              = pe_rvalid[i];
            raddr               = pe_raddr[i*26 +: 26];
            wvalid              = pe_wvalid[i];
            waddr               = pe_waddr[i*26 +: 26];
            wdata               = pe_wdata[i*32 +: 32];
            pe_rready[i]        = rready;
            pe_wready[i]        = wready;
            pe_rdata[i*32 +: 32] = rdata;
          end else begin
            pe_rready[i] = 1'b0;
          end
        end

        // A read and write beat in the same cycle count once; saturate at 255.
        if (w_beat && (r_beats != 8'hFF)) begin
          w_beats_nxt = r_beats + 8'd1;
        end else begin
          w_beats_nxt = r_beats;
        end

        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = (r_gidx == PW'(NPE - 1)) ? '0 : (r_gidx + 1'b1);
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and arbitration registers; reset aborts any grant at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_beats <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_beats <= w_beats_nxt;
    end
  end

endmodule
